// File: rtl/seq_pkg.sv
// Shared definitions for the sequence player: FSM encoding and the power-up table.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam int DEFAULT_N = 8;
    localparam int DEFAULT_SEQ [DEFAULT_N] = '{6, 9, 11, 15, 10, 8, 2, 5};

    // Entries beyond the built-in pattern power up as zero.
    function automatic int default_entry(input int i);
        int v;
        v = 0;
        if (i >= 0 && i < DEFAULT_N) begin
            v = DEFAULT_SEQ[i];
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_div_cnt.sv
// Loadable down-counter that times the idle gap before each presented entry.
module seq_div_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/seq_play_ctrl.sv
// Run-time programmable sequence player: register table, spacing timer and
// valid/ready output stage with single/multi/endless pass control.
module seq_play_ctrl
    import seq_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [7:0]        cfg_loops,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state;
    logic [DATA_W-1:0]   table_reg [DEPTH];
    logic [ADDR_W-1:0]   idx_reg;
    logic [ADDR_W:0]     len_reg;
    logic [7:0]          loops_reg;
    logic [7:0]          loop_cnt_reg;
    logic [DIV_W-1:0]    div_reg;

    logic                tab_we;
    logic                len_ok;
    logic                last;
    logic                div_load;
    logic                div_en;
    logic [DIV_W-1:0]    div_load_val;
    logic [DIV_W-1:0]    div_cnt;
    logic                div_zero;

    assign tab_we = cfg_we && (state == IDLE);
    assign len_ok = (cfg_len != '0) && (cfg_len <= (ADDR_W+1)'(DEPTH));
    assign last   = ({1'b0, idx_reg} == (len_reg - 1'b1));
    assign busy   = (state != IDLE);

    // The spacing timer is reloaded on a legal start and after every accepted entry.
    assign div_load     = ((state == IDLE) && start && !stop && len_ok) ||
                          ((state == EMIT) && out_ready && !stop);
    assign div_load_val = (state == IDLE) ? cfg_div : div_reg;
    assign div_en       = (state == WAIT) && en && !stop && (div_cnt != '0);

    seq_div_cnt #(
        .W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (div_load),
        .en       (div_en),
        .load_val (div_load_val),
        .value    (div_cnt),
        .zero     (div_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_reg[i] <= DATA_W'(default_entry(i));
            end
        end else if (tab_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cfg_addr == ADDR_W'(i)) begin
                    table_reg[i] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            out_valid    <= 1'b0;
            out_data     <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            idx_reg      <= '0;
            len_reg      <= '0;
            loops_reg    <= '0;
            loop_cnt_reg <= '0;
            div_reg      <= '0;
        end else begin
            done <= 1'b0;
            err  <= cfg_we && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (len_ok) begin
                            len_reg      <= cfg_len;
                            loops_reg    <= cfg_loops;
                            loop_cnt_reg <= cfg_loops;
                            div_reg      <= cfg_div;
                            idx_reg      <= '0;
                            state        <= WAIT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (div_zero) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_data  <= table_reg[idx_reg];
                    end
                end
                EMIT: begin
                    // Abort is the only way out of EMIT without a handshake.
                    if (stop) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!last) begin
                            idx_reg <= idx_reg + 1'b1;
                            state   <= WAIT;
                        end else if (loops_reg == 8'd0) begin
                            idx_reg <= '0;
                            state   <= WAIT;
                        end else if (loop_cnt_reg > 8'd1) begin
                            idx_reg      <= '0;
                            loop_cnt_reg <= loop_cnt_reg - 8'd1;
                            state        <= WAIT;
                        end else begin
                            idx_reg <= '0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
